// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings and FSM states.
// The multiplier encodings are only meaningful when ALU_SEQ_MUL_EN is defined.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_MUL = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_addsub.sv
// Combinational WIDTH-bit adder/subtractor. Subtract is A + ~B + 1, selected
// by b_invert with cin = 1. Shared by ADD/SUB/SLT and the multiplier step.
module alu_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_invert,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  logic [WIDTH-1:0] b_eff;
  logic             carry_msb;

  assign b_eff = b_invert ? ~b : b;
  assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
  // Carry into the MSB recovered from the MSB sum bit and its operands.
  assign carry_msb = sum[WIDTH-1] ^ a[WIDTH-1] ^ b_eff[WIDTH-1];
  assign overflow  = carry_msb ^ cout;

endmodule

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with an optional iterative shift-add multiplier.
// Macro ALU_SEQ_MUL_EN enables MUL (BUSY/DONE states, product registers);
// without it opcode 1000 is an unsupported code and ready_o is always 1.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ctrl_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             overflow_o,
  output logic             cout_o
);

  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic             add_binv, add_cout, add_ovf;
  logic [WIDTH-1:0] op_res;
  logic             op_ovf, op_cout;
  logic             accept, start_mul, is_sub;

  logic [WIDTH-1:0] result_q;
  logic             valid_q, zero_q, ovf_q, cout_q;

  assign is_sub = (ctrl_i == ALU_SUB) || (ctrl_i == ALU_SLT);
  assign accept = valid_i && ready_o;

`ifdef ALU_SEQ_MUL_EN
  localparam int              CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_e             state;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod, prod_next;
  logic               mul_last;

  assign ready_o   = (state != S_BUSY);
  assign start_mul = accept && (ctrl_i == ALU_MUL);
  assign mul_last  = (state == S_BUSY) && (count == LAST);

  // While busy the shared adder forms high-half + multiplicand.
  assign add_a    = (state == S_BUSY) ? prod[2*WIDTH-1:WIDTH] : src1_i;
  assign add_b    = (state == S_BUSY) ? mcand : src2_i;
  assign add_binv = (state != S_BUSY) && is_sub;

  // prod = {partial high, remaining multiplier bits}; add if LSB set, then shift right.
  assign prod_next = prod[0] ? {add_cout, add_sum, prod[WIDTH-1:1]}
                             : {1'b0, prod[2*WIDTH-1:1]};

  // FSM: IDLE/DONE accept work, BUSY runs WIDTH steps then reports in DONE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      count <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_mul) begin
            state <= S_BUSY;
            count <= '0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_BUSY: begin
          if (count == LAST) begin
            state <= S_DONE;
            count <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Multiplier datapath: latch operands at accept, step once per busy cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcand <= '0;
      prod  <= '0;
    end else if (start_mul) begin
      mcand <= src1_i;
      prod  <= {{WIDTH{1'b0}}, src2_i};
    end else if (state == S_BUSY) begin
      prod <= prod_next;
    end
  end
`else
  assign ready_o   = 1'b1;
  assign start_mul = 1'b0;
  assign add_a     = src1_i;
  assign add_b     = src2_i;
  assign add_binv  = is_sub;
`endif

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a        (add_a),
    .b        (add_b),
    .b_invert (add_binv),
    .cin      (add_binv),
    .sum      (add_sum),
    .cout     (add_cout),
    .overflow (add_ovf)
  );

  // Single-cycle result and flags; unknown codes fall through to all-zero.
  always_comb begin
    op_res  = '0;
    op_ovf  = 1'b0;
    op_cout = 1'b0;
    case (ctrl_i)
      ALU_AND: op_res = src1_i & src2_i;
      ALU_OR:  op_res = src1_i | src2_i;
      ALU_NOR: op_res = ~(src1_i | src2_i);
      ALU_ADD, ALU_SUB: begin
        op_res  = add_sum;
        op_ovf  = add_ovf;
        op_cout = add_cout;
      end
      ALU_SLT: begin
        op_res  = {{(WIDTH-1){1'b0}}, add_sum[WIDTH-1] ^ add_ovf};
        op_cout = add_cout;
      end
      default: ;
    endcase
  end

  // Result registers update only on completion and otherwise hold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (accept && !start_mul) begin
        valid_q  <= 1'b1;
        result_q <= op_res;
        zero_q   <= (op_res == '0);
        ovf_q    <= op_ovf;
        cout_q   <= op_cout;
      end
`ifdef ALU_SEQ_MUL_EN
      else if (mul_last) begin
        valid_q  <= 1'b1;
        result_q <= prod_next[WIDTH-1:0];
        zero_q   <= (prod_next[WIDTH-1:0] == '0);
        ovf_q    <= |prod_next[2*WIDTH-1:WIDTH];
        cout_q   <= 1'b0;
      end
`endif
    end
  end

  assign valid_o    = valid_q;
  assign result_o   = result_q;
  assign zero_o     = zero_q;
  assign overflow_o = ovf_q;
  assign cout_o     = cout_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32). MUL scenarios are exercised when
// ALU_SEQ_MUL_EN is defined; otherwise MUL is checked as an unsupported code.
module tb_alu_seq;

  localparam int W = 32;
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010,
                         OP_SUB = 4'b0110, OP_SLT = 4'b0111, OP_NOR = 4'b1100,
                         OP_MUL = 4'b1000;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         valid_i = 1'b0;
  logic         ready_o;
  logic [W-1:0] src1_i = '0, src2_i = '0;
  logic [3:0]   ctrl_i = '0;
  logic         valid_o;
  logic [W-1:0] result_o;
  logic         zero_o, overflow_o, cout_o;

  int total = 0;
  int bad   = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .src1_i(src1_i), .src2_i(src2_i), .ctrl_i(ctrl_i), .valid_o(valid_o),
    .result_o(result_o), .zero_o(zero_o), .overflow_o(overflow_o), .cout_o(cout_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference: {valid, result, zero, overflow, cout} from plain arithmetic.
  function automatic logic [W+3:0] model(input logic [3:0] c, input logic [W-1:0] a, b);
    logic [W-1:0] r;
    logic ov, co;
    longint sa, sb, d;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; ov = 1'b0; co = 1'b0;
    case (c)
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_NOR: r = ~(a | b);
      OP_ADD: begin
        {co, r} = {1'b0, a} + {1'b0, b};
        d = sa + sb;
        ov = (d > 64'sd2147483647) || (d < -64'sd2147483648);
      end
      OP_SUB: begin
        r = a - b;
        co = (a >= b);
        d = sa - sb;
        ov = (d > 64'sd2147483647) || (d < -64'sd2147483648);
      end
      OP_SLT: begin
        r = (sa < sb) ? 1 : 0;
        co = (a >= b);
      end
`ifdef ALU_SEQ_MUL_EN
      OP_MUL: begin
        p = 64'(a) * 64'(b);
        r = p[31:0];
        ov = |p[63:32];
      end
`endif
      default: ;
    endcase
    return {1'b1, r, (r == '0), ov, co};
  endfunction

  // Present a request for one edge; returns 1 time unit after the accepting edge.
  task automatic issue(input logic [3:0] c, input logic [W-1:0] a, b);
    valid_i = 1'b1; ctrl_i = c; src1_i = a; src2_i = b;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    logic [W+3:0] got;
    rst_i = 1'b1;
    repeat (3) tick();
    got = {valid_o, result_o, zero_o, overflow_o, cout_o};
    total++;
    if (got !== {1'b0, {W{1'b0}}, 1'b1, 1'b0, 1'b0} || ready_o !== 1'b1) begin
      bad++; $display("FAIL reset_state got=%h ready=%b exp=%h ready=1", got, ready_o,
                      {1'b0, {W{1'b0}}, 1'b1, 1'b0, 1'b0});
    end
    // Request coincident with reset is dropped.
    valid_i = 1'b1; ctrl_i = OP_ADD; src1_i = 32'd3; src2_i = 32'd4;
    tick();
    valid_i = 1'b0; rst_i = 1'b0;
    total++;
    if (valid_o !== 1'b0 || result_o !== '0) begin
      bad++; $display("FAIL reset_wins got valid=%b res=%h exp valid=0 res=0", valid_o, result_o);
    end
    tick();
    total++;
    if (valid_o !== 1'b0 || result_o !== '0) begin
      bad++; $display("FAIL reset_drop got valid=%b res=%h exp valid=0 res=0", valid_o, result_o);
    end
  endtask

  task automatic test_directed();
    logic [3:0]   cs [9] = '{OP_ADD, OP_SUB, OP_NOR, OP_SLT, OP_SLT, OP_SLT, OP_AND, OP_OR, 4'b0011};
    logic [W-1:0] as [9] = '{32'h7FFFFFFF, 32'd5, 32'd0, 32'hFFFFFFFF, 32'h1, 32'h80000000,
                             32'hF0F0F0F0, 32'h0F, 32'h1234};
    logic [W-1:0] bs [9] = '{32'h1, 32'd5, 32'd0, 32'h1, 32'hFFFFFFFF, 32'h1,
                             32'hFF00FF00, 32'hF0, 32'h5678};
    logic [W+3:0] ex [9] = '{{1'b1, 32'h80000000, 3'b010}, {1'b1, 32'h0, 3'b101},
                             {1'b1, 32'hFFFFFFFF, 3'b000}, {1'b1, 32'h1, 3'b001},
                             {1'b1, 32'h0, 3'b100}, {1'b1, 32'h1, 3'b001},
                             {1'b1, 32'hF000F000, 3'b000}, {1'b1, 32'hFF, 3'b000},
                             {1'b1, 32'h0, 3'b100}};
    logic [W+3:0] got;
    for (int i = 0; i < 9; i++) begin
      issue(cs[i], as[i], bs[i]);
      got = {valid_o, result_o, zero_o, overflow_o, cout_o};
      total++;
      if (got !== ex[i]) begin
        bad++; $display("FAIL directed_%0d got=%h exp=%h", i, got, ex[i]);
      end
      tick();
      total++;
      if (valid_o !== 1'b0 || result_o !== ex[i][W+2:3]) begin
        bad++; $display("FAIL pulse_hold_%0d got valid=%b res=%h exp valid=0 res=%h",
                        i, valid_o, result_o, ex[i][W+2:3]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]   ops [6] = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR};
    logic [3:0]   c;
    logic [W-1:0] a, b;
    logic [W+3:0] got, exp;
    for (int i = 0; i < 12; i++) begin
      c = ops[$urandom_range(0, 5)];
      a = $urandom; b = $urandom;
      issue(c, a, b);
      valid_i = 1'b1;  // keep the request line high between accepts
      exp = model(c, a, b);
      got = {valid_o, result_o, zero_o, overflow_o, cout_o};
      total++;
      if (got !== exp || ready_o !== 1'b1) begin
        bad++; $display("FAIL b2b_%0d op=%b got=%h exp=%h ready=%b", i, c, got, exp, ready_o);
      end
    end
    valid_i = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [3:0]   ops [8] = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_MUL, 4'b0000};
    logic [W-1:0] edges [5] = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h1};
    logic [3:0]   c;
    logic [W-1:0] a, b;
    logic [W+3:0] got, exp;
    int n;
    for (int i = 0; i < 40; i++) begin
      c = ops[$urandom_range(0, 7)];
      if (i % 8 == 7) c = 4'($urandom);
      a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
      issue(c, a, b);
      n = 0;
      while (!valid_o && n < 40) begin tick(); n++; end
      exp = model(c, a, b);
      got = {valid_o, result_o, zero_o, overflow_o, cout_o};
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL rand_%0d op=%b a=%h b=%h got=%h exp=%h", i, c, a, b, got, exp);
      end
    end
    tick();
  endtask

`ifdef ALU_SEQ_MUL_EN
  task automatic test_mul();
    int lat, busy;
    logic [W+3:0] got;
    issue(OP_MUL, 32'd7, 32'd6);
    lat = 1; busy = 0;
    while (!valid_o && lat < 40) begin
      if (!ready_o) busy++;
      if (lat == 5) begin valid_i = 1'b1; ctrl_i = OP_ADD; src1_i = 32'd1; src2_i = 32'd1; end
      if (lat == 7) valid_i = 1'b0;
      tick(); lat++;
    end
    total++;
    if (lat !== 33 || busy !== 32 || ready_o !== 1'b1) begin
      bad++; $display("FAIL mul_timing got lat=%0d busy=%0d ready=%b exp lat=33 busy=32 ready=1",
                      lat, busy, ready_o);
    end
    got = {valid_o, result_o, zero_o, overflow_o, cout_o};
    total++;
    if (got !== {1'b1, 32'd42, 3'b000}) begin
      bad++; $display("FAIL mul_7x6 got=%h exp=%h", got, {1'b1, 32'd42, 3'b000});
    end
    tick();
    total++;
    if (valid_o !== 1'b0 || result_o !== 32'd42) begin
      bad++; $display("FAIL mul_no_extra got valid=%b res=%h exp valid=0 res=2a", valid_o, result_o);
    end

    issue(OP_MUL, 32'h00010000, 32'h00010000);
    lat = 1;
    while (!valid_o && lat < 40) begin tick(); lat++; end
    got = {valid_o, result_o, zero_o, overflow_o, cout_o};
    total++;
    if (got !== {1'b1, 32'h0, 3'b110}) begin
      bad++; $display("FAIL mul_ovf got=%h exp=%h", got, {1'b1, 32'h0, 3'b110});
    end
    // Second MUL accepted in the DONE cycle.
    issue(OP_MUL, 32'd3, 32'd5);
    lat = 1;
    while (!valid_o && lat < 40) begin tick(); lat++; end
    total++;
    if (lat !== 33 || result_o !== 32'd15 || overflow_o !== 1'b0) begin
      bad++; $display("FAIL mul_in_done got lat=%0d res=%h ovf=%b exp lat=33 res=f ovf=0",
                      lat, result_o, overflow_o);
    end

    // Reset at busy step 10 aborts the multiply.
    issue(OP_MUL, 32'd9, 32'd9);
    repeat (10) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    total++;
    if (ready_o !== 1'b1 || result_o !== '0 || valid_o !== 1'b0 || zero_o !== 1'b1) begin
      bad++; $display("FAIL mul_reset got ready=%b res=%h valid=%b zero=%b exp ready=1 res=0 valid=0 zero=1",
                      ready_o, result_o, valid_o, zero_o);
    end
    busy = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid_o) busy++;
      tick();
    end
    total++;
    if (busy !== 0) begin
      bad++; $display("FAIL mul_abort got valids=%0d exp=0", busy);
    end
  endtask
`else
  task automatic test_mul_disabled();
    logic [W+3:0] got;
    issue(OP_MUL, 32'd7, 32'd6);
    got = {valid_o, result_o, zero_o, overflow_o, cout_o};
    total++;
    if (got !== {1'b1, 32'h0, 3'b100} || ready_o !== 1'b1) begin
      bad++; $display("FAIL mul_disabled got=%h ready=%b exp=%h ready=1", got, ready_o,
                      {1'b1, 32'h0, 3'b100});
    end
    tick();
    total++;
    if (valid_o !== 1'b0) begin
      bad++; $display("FAIL mul_disabled_pulse got valid=%b exp=0", valid_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
`ifdef ALU_SEQ_MUL_EN
    test_mul();
`else
    test_mul_disabled();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised WIDTH-bit ALU for the lab CPU datapath. It registers every result and adds an iterative shift-add multiplier behind a valid/ready handshake. Single-cycle ops complete in one clock. MUL holds the unit busy for WIDTH cycles. The block sits between the register-file read stage and write-back, driven by the ALU-control decode.

## Interface
- WIDTH, 32, operand/result width in bits (≥ 2)
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, synchronous, active-high
- valid_i  in  1  request present
- ready_o  out  1  unit can accept a request this cycle
- src1_i  in  WIDTH  operand A
- src2_i  in  WIDTH  operand B
- ctrl_i  in  4  operation code
- valid_o  out  1  result valid, one-cycle pulse
- result_o  out  WIDTH  registered result
- zero_o  out  1  result_o == 0
- overflow_o  out  1  signed overflow (ADD/SUB), upper half non-zero (MUL)
- cout_o  out  1  adder carry-out (ADD/SUB/SLT), else 0

## Operation
- Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1000 MUL; any other code gives result 0, zero_o 1, flags 0.
- SUB/SLT: A + ~B + 1. cout_o is the carry out of the MSB; overflow_o = carry into MSB XOR carry out.
- SLT: result = {0…0, sign XOR overflow}, signed compare. overflow_o is forced to 0 for SLT.
- MUL: unsigned, WIDTH×WIDTH. result_o = low WIDTH bits of the product. overflow_o = |(high WIDTH bits). Operands are latched at accept.
- Accept: valid_i && ready_o at a rising edge.
- FSM states:
  - IDLE: ready_o = 1. A single-cycle op is computed and registered, and stays in IDLE. MUL goes to BUSY with count = 0.
  - BUSY: ready_o = 0. One add/shift step per cycle; count increments. After step WIDTH-1, go to DONE.
  - DONE: valid_o = 1 and ready_o = 1. A request accepted here behaves as if accepted in IDLE; otherwise return to IDLE.
- valid_i while ready_o = 0 is ignored. The requester must hold the request until it is accepted.
- result_o, zero_o, overflow_o and cout_o hold their last values until the next completion.

## Timing
- Reset values: state IDLE, ready_o 1, valid_o 0, result_o 0, zero_o 1, overflow_o 0, cout_o 0, count 0.
- Single-cycle ops: accept at edge k gives valid_o high in cycle k+1 only. Back-to-back accepts are allowed every cycle.
- MUL: accept at edge k.
  - ready_o is low from cycle k+1 to cycle k+WIDTH.
  - valid_o is high in cycle k+WIDTH+1.
  - Total latency is WIDTH+1 cycles.
- count is ⌈log2 WIDTH⌉+1 bits. It does not wrap during an operation.
- Reset asserted mid-MUL aborts the operation: no valid_o, and state and outputs take reset values at the next edge.
- rst_i and valid_i asserted together: reset wins and the request is dropped.

## Configuration
- ALU_SEQ_MUL_EN defined: MUL is implemented as described, with the BUSY/DONE states and the product registers.
- ALU_SEQ_MUL_EN undefined:
  - opcode 1000 is treated as an unsupported code (result 0, single-cycle, valid_o next cycle);
  - ready_o is constantly 1 outside reset;
  - BUSY/DONE logic and multiplier registers are not synthesised.

## Structure
- Package alu_pkg holds:
  - ctrl opcode localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, ALU_MUL);
  - the FSM state enum (S_IDLE, S_BUSY, S_DONE).
- Sub-module alu_addsub: combinational WIDTH-bit add/subtract with b_invert and cin inputs, giving sum, cout and overflow. It is shared by ADD, SUB, SLT and the multiplier's partial-sum step.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 → result 0x80000000, overflow_o 1, cout_o 0, valid_o exactly one cycle after accept.
- SUB 5 − 5 → result 0, zero_o 1, cout_o 1, overflow_o 0; NOR 0 → 0xFFFFFFFF.
- SLT 0xFFFFFFFF vs 0x00000001 → 1; SLT 0x00000001 vs 0xFFFFFFFF → 0; SLT 0x80000000 vs 0x00000001 → 1.
- MUL 7 × 6 → 42, overflow_o 0.
  - ready_o is low for 32 cycles and valid_o arrives 33 cycles after accept.
  - A valid_i pulse with ADD during BUSY produces no extra valid_o.
- MUL 0x00010000 × 0x00010000 → result 0, overflow_o 1, zero_o 1.
  - A second MUL accepted in the DONE cycle completes 33 cycles later.
- rst_i asserted at BUSY step 10 → next cycle ready_o 1 and result_o 0, with no valid_o.
  - With ALU_SEQ_MUL_EN undefined: MUL 7 × 6 → result 0 with valid_o next cycle.
